// File: rtl/pe_instr_sequencer.sv
// rtl/pe_instr_sequencer.sv - instruction FIFO and single-op issue sequencer for the PE core
module pe_instr_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int TIMEOUT     = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [INSTR_WIDTH-1:0]         in_instr,
    output logic                           in_ready,
    input  logic                           flush,
    output logic                           pe_start,
    output logic [INSTR_WIDTH-1:0]         pe_instruction,
    input  logic                           pe_done,
    output logic                           cmp_valid,
    output logic [3:0]                     cmp_opcode,
    output logic [CNT_WIDTH-1:0]           cmp_cycles,
    output logic                           cmp_timeout,
    output logic                           err_illegal,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE
    } state_t;

    state_t state, state_next;

    logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;
    logic [INSTR_WIDTH-1:0] head;
    logic [3:0]             head_op;
    logic                   head_legal;
    logic [CNT_WIDTH-1:0]   wait_cnt, cnt_inc;
    logic                   wait_end;

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign in_ready   = !fifo_full && !flush;
    assign push       = in_valid && in_ready;
    // flush outranks a pending pop so nothing leaves the queue on a flush cycle
    assign pop        = (state == S_IDLE) && !fifo_empty && !flush;

    assign head       = mem[rd_ptr];
    assign head_op    = head[INSTR_WIDTH-1 -: 4];
    assign head_legal = (head_op == 4'h1) || (head_op == 4'h2) || (head_op == 4'h3);

    assign cnt_inc    = wait_cnt + CNT_WIDTH'(1);
    assign wait_end   = pe_done || (cnt_inc == TIMEOUT_CNT);

    assign fifo_level = level;
    assign busy       = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pe_start   = 1'b0;
        cmp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop && head_legal) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pe_start   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (wait_end) begin
                    state_next = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                cmp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pe_instruction <= '0;
            wait_cnt       <= '0;
            cmp_opcode     <= '0;
            cmp_cycles     <= '0;
            cmp_timeout    <= 1'b0;
            err_illegal    <= 1'b0;
        end else begin
            if (pop) begin
                if (head_legal) begin
                    pe_instruction <= head;
                end else begin
                    err_illegal <= 1'b1;
                end
            end
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end
            if (state == S_WAIT) begin
                wait_cnt <= cnt_inc;
                // completion fields are captured on entry to COMPLETE and held until the next one
                if (wait_end) begin
                    cmp_opcode  <= pe_instruction[INSTR_WIDTH-1 -: 4];
                    cmp_cycles  <= cnt_inc;
                    cmp_timeout <= !pe_done;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_instr_sequencer.sv
// tb/tb_pe_instr_sequencer.sv - directed scoreboard bench for pe_instr_sequencer
module tb_pe_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        pe_start;
    logic [31:0] pe_instruction;
    logic        pe_done;
    logic        cmp_valid;
    logic [3:0]  cmp_opcode;
    logic [15:0] cmp_cycles;
    logic        cmp_timeout;
    logic        err_illegal;
    logic        busy;
    logic [2:0]  fifo_level;

    pe_instr_sequencer #(
        .FIFO_DEPTH (4),
        .INSTR_WIDTH(32),
        .TIMEOUT    (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .flush         (flush),
        .pe_start      (pe_start),
        .pe_instruction(pe_instruction),
        .pe_done       (pe_done),
        .cmp_valid     (cmp_valid),
        .cmp_opcode    (cmp_opcode),
        .cmp_cycles    (cmp_cycles),
        .cmp_timeout   (cmp_timeout),
        .err_illegal   (err_illegal),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] cycles;
        logic        to;
    } cmp_t;

    cmp_t        exp_cmp_q[$];
    logic [31:0] exp_start_q[$];
    int          delay_q[$];
    int          start_cyc_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_start = 0;
    int          pe_cnt = 0;
    int          last_push_cyc = 0;
    int          s0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PE core model and completion scoreboard, both on the falling edge
    always @(negedge clk) begin
        cmp_t e;
        pe_done = 1'b0;
        if (rst) begin
            pe_cnt = 0;
        end else begin
            if (pe_start) begin
                n_start++;
                start_cyc_q.push_back(cyc);
                if (exp_start_q.size() == 0) begin
                    check("unexpected_start", pe_start, 1'b0);
                    pe_cnt = 0;
                end else begin
                    check("start_instr", pe_instruction, exp_start_q.pop_front());
                    pe_cnt = delay_q.pop_front();
                end
            end else if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0) pe_done = 1'b1;
            end
            if (cmp_valid) begin
                if (exp_cmp_q.size() == 0) begin
                    check("unexpected_cmp", cmp_valid, 1'b0);
                end else begin
                    e = exp_cmp_q.pop_front();
                    check("cmp_opcode", 32'(cmp_opcode), 32'(e.op));
                    check("cmp_cycles", 32'(cmp_cycles), 32'(e.cycles));
                    check("cmp_timeout", 32'(cmp_timeout), 32'(e.to));
                end
            end
        end
    end

    task automatic push(input logic [31:0] instr, input int dly, input bit exp_start,
                        input bit exp_cmp, input int cycles, input bit to);
        int n;
        cmp_t e;
        in_valid = 1'b1;
        in_instr = instr;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        last_push_cyc = cyc;
        if (exp_start) begin
            exp_start_q.push_back(instr);
            delay_q.push_back(dly);
        end
        if (exp_cmp) begin
            e.op     = instr[31:28];
            e.cycles = 16'(cycles);
            e.to     = to;
            exp_cmp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || exp_cmp_q.size() != 0 || exp_start_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cmp_pending", exp_cmp_q.size(), 32'd0);
    endtask

    task automatic wait_start(input int bound);
        int n;
        n = 0;
        while (!pe_start && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("saw_start", 32'(pe_start), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_pe_start"}, 32'(pe_start), 32'd0);
        check({tag, "_pe_instruction"}, pe_instruction, 32'd0);
        check({tag, "_cmp_valid"}, 32'(cmp_valid), 32'd0);
        check({tag, "_cmp_opcode"}, 32'(cmp_opcode), 32'd0);
        check({tag, "_cmp_cycles"}, 32'(cmp_cycles), 32'd0);
        check({tag, "_cmp_timeout"}, 32'(cmp_timeout), 32'd0);
        check({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        flush    = 1'b0;
        pe_done  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // single MAC, done in the third WAIT cycle
        s0 = n_start;
        start_cyc_q.delete();
        push(32'h1000_0000, 3, 1, 1, 3, 0);
        wait_idle(40);
        check("t1_starts", n_start - s0, 32'd1);
        check("t1_latency", start_cyc_q[0], last_push_cyc + 2);
        check("t1_instr_held", pe_instruction, 32'h1000_0000);

        // three back-to-back ops, done after one WAIT cycle each
        s0 = n_start;
        start_cyc_q.delete();
        push(32'h2000_0001, 1, 1, 1, 1, 0);
        push(32'h3000_0000, 1, 1, 1, 1, 0);
        push(32'h1000_0000, 1, 1, 1, 1, 0);
        wait_idle(60);
        check("t2_starts", n_start - s0, 32'd3);
        check("t2_gap01", start_cyc_q[1] - start_cyc_q[0], 32'd4);
        check("t2_gap12", start_cyc_q[2] - start_cyc_q[1], 32'd4);

        // timeout then a normal op
        s0 = n_start;
        push(32'h3000_0000, 0, 1, 1, 8, 1);
        push(32'h1000_0000, 2, 1, 1, 2, 0);
        wait_idle(80);
        check("t3_starts", n_start - s0, 32'd2);
        check("t3_timeout_cleared", 32'(cmp_timeout), 32'd0);

        // illegal opcode is dropped, sticky error
        s0 = n_start;
        check("t4_err_before", 32'(err_illegal), 32'd0);
        push(32'hF000_0000, 0, 0, 0, 0, 0);
        push(32'h2000_0000, 1, 1, 1, 1, 0);
        wait_idle(40);
        check("t4_err_set", 32'(err_illegal), 32'd1);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", 32'(err_illegal), 32'd1);
        check("t4_starts", n_start - s0, 32'd1);

        // fill FIFO behind a stalled op, then flush during WAIT
        s0 = n_start;
        push(32'h1000_0000, 0, 1, 1, 8, 1);
        wait_start(20);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h2000_0000 | 32'(i);
            @(negedge clk);
        end
        in_instr = 32'h3000_0005;
        check("t5_level_full", 32'(fifo_level), 32'd4);
        check("t5_ready_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t5_level_after_drop", 32'(fifo_level), 32'd4);
        in_valid = 1'b0;
        flush    = 1'b1;
        check("t5_ready_flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("t5_level_flushed", 32'(fifo_level), 32'd0);
        check("t5_inflight_busy", 32'(busy), 32'd1);
        wait_idle(40);
        repeat (10) @(negedge clk);
        check("t5_starts", n_start - s0, 32'd1);
        check("t5_level_end", 32'(fifo_level), 32'd0);

        // reset during WAIT aborts silently, then a normal op
        s0 = n_start;
        push(32'h1000_0000, 0, 1, 0, 0, 0);
        wait_start(20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        @(negedge clk);
        check("t6_no_cmp", 32'(cmp_valid), 32'd0);
        push(32'h1000_0000, 2, 1, 1, 2, 0);
        wait_idle(40);
        check("t6_starts", n_start - s0, 32'd2);
        check("t6_instr", pe_instruction, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_instr_sequencer.md
Name: pe_instr_sequencer

Overview:
Instruction sequencer in front of the PE core. Buffers 32-bit PE instructions in a small FIFO and issues them one at a time over the core's start/instruction/done handshake. Tracks per-operation latency, detects hung operations with a timeout, and rejects illegal opcodes. Sits between the host/command path and pe_core_complete; issues exactly one operation at a time.

Parameters:
FIFO_DEPTH, 4, instruction FIFO entries (power of 2, >=2)
INSTR_WIDTH, 32, instruction width; opcode = instr[INSTR_WIDTH-1 -: 4]
TIMEOUT, 64, max WAIT cycles before an op is abandoned (>=2)
CNT_WIDTH, 16, width of cycle counter / cmp_cycles (must hold TIMEOUT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction offered
in_instr  in  INSTR_WIDTH  instruction payload
in_ready  out  1  = !fifo_full && !flush
flush  in  1  discard all queued (not in-flight) instructions
pe_start  out  1  one-cycle start pulse to PE core
pe_instruction  out  INSTR_WIDTH  instruction to PE core, stable ISSUE through WAIT
pe_done  in  1  PE core completion (level or pulse; first WAIT-cycle high counts)
cmp_valid  out  1  one-cycle completion strobe
cmp_opcode  out  4  opcode of completed op
cmp_cycles  out  CNT_WIDTH  WAIT cycles consumed, done cycle included
cmp_timeout  out  1  qualifies cmp_valid: op ended by timeout
err_illegal  out  1  sticky: an illegal opcode was popped; cleared only by rst
busy  out  1  state != IDLE or FIFO non-empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock is clk; reset is synchronous, active-high. rst clears FIFO pointers/level, state=IDLE. Reset values: in_ready=1 (after reset cycle), pe_start=0, pe_instruction=0, cmp_valid=0, cmp_opcode=0, cmp_cycles=0, cmp_timeout=0, err_illegal=0, busy=0, fifo_level=0. rst mid-operation aborts the op with no cmp_valid; PE core reset is the system's responsibility.
- Legal opcodes: 4'h1 MAC, 4'h2 ACT, 4'h3 NORM. All others illegal.
- FIFO: push on in_valid&&in_ready. Pop occurs only in IDLE. Simultaneous push and pop allowed in the same cycle; level unchanged. Pointers wrap modulo FIFO_DEPTH. Full: in_ready=0, in_valid ignored, no overwrite. Empty: no pop.
- flush: same-cycle clear of FIFO (level=0 next cycle), in_ready=0 that cycle, so a concurrent push is dropped. An in-flight op (ISSUE/WAIT/COMPLETE) is unaffected and still completes. flush in IDLE with a pop pending: flush wins, nothing popped.
- FSM states: IDLE, ISSUE, WAIT, COMPLETE.
  - IDLE: if FIFO non-empty, pop head.
    - Legal head: latch into pe_instruction, go to ISSUE.
    - Illegal head: set err_illegal, stay IDLE. The next entry may pop the following cycle. No cmp_valid.
  - ISSUE: pe_start=1 for exactly this cycle. Clear cycle counter. Go to WAIT. pe_done is ignored here.
  - WAIT: counter increments every cycle (first WAIT cycle counts as 1).
    - pe_done=1: go to COMPLETE with timeout=0.
    - Else counter==TIMEOUT: go to COMPLETE with timeout=1.
    - pe_done and counter==TIMEOUT in the same cycle: done wins, timeout=0.
  - COMPLETE: cmp_valid=1 one cycle. cmp_opcode, cmp_cycles, cmp_timeout are valid and held until the next COMPLETE. Go to IDLE.
- Latency: push at edge N. IDLE pops in cycle N+1. pe_start is high in cycle N+2. If pe_done is high in the first WAIT cycle (N+3), cmp_valid is in N+4 with cmp_cycles=1. Back-to-back ops: minimum 4 cycles from pe_start to the next pe_start.
- pe_instruction holds its last value after completion; it does not return to 0.

Test Plan:
1. Reset, push 32'h10000000; PE model raises pe_done 3 cycles after pe_start -> exactly one pe_start pulse, pe_instruction=32'h10000000, cmp_valid once with cmp_opcode=1, cmp_cycles=3, cmp_timeout=0.
2. Push 32'h20000001, 32'h30000000, 32'h10000000 back-to-back; done after 1 WAIT cycle each -> three pe_start pulses 4 cycles apart, cmp_opcode sequence 2,3,1, cmp_cycles=1 each.
3. TIMEOUT=8, push 32'h30000000, pe_done held 0 -> cmp_valid with cmp_timeout=1, cmp_cycles=8. Then the next queued op issues normally.
4. Push 32'hF0000000 then 32'h20000000 -> err_illegal=1 and stays 1, no pe_start for the first, one pe_start/completion (opcode 2) for the second.
5. Stall PE (no done), push until full -> fifo_level=4, in_ready=0, 5th push dropped. Assert flush while in WAIT -> level=0 next cycle, in-flight op still completes, no further pe_start.
6. Assert rst during WAIT -> next cycle all outputs at reset values, no cmp_valid. Subsequent push 32'h10000000 is sequenced normally.
